// File: rtl/mem_req_queue.sv
// In-order request queue in front of the MAIN memory stage.
// Reads return their data on a registered one-cycle response pulse.
module mem_req_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_rw,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_data,
    output logic                       mem_en,
    output logic                       mem_RW,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_dataIN,
    input  logic                       mem_ready,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       resp_valid,
    output logic [DATA_W-1:0]          resp_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic              rw_mem   [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             rd_pend;
    logic             push;
    logic             pop;

    assign req_ready  = (count != FULL_COUNT);
    assign mem_en     = (count != '0);
    assign mem_RW     = rw_mem[rd_ptr];
    assign mem_addr   = addr_mem[rd_ptr];
    assign mem_dataIN = data_mem[rd_ptr];

    assign push = req_valid && req_ready;
    assign pop  = mem_en && mem_ready;

    // Storage needs no reset: entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            rw_mem[wr_ptr]   <= req_rw;
            addr_mem[wr_ptr] <= req_addr;
            data_mem[wr_ptr] <= req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_pend <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count   <= count + CNT_W'(push) - CNT_W'(pop);
            rd_pend <= pop && !mem_RW;
        end
    end

    // MAIN returns read data one cycle after acceptance; capture it then.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else begin
            resp_valid <= rd_pend;
            if (rd_pend) resp_data <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_req_queue.sv
// Self-checking bench for mem_req_queue: directed table, hand sequences,
// and randomized traffic against a queue-based reference model.
module tb_mem_req_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_rw;
    logic [7:0]  req_addr;
    logic [31:0] req_data;
    logic        mem_en;
    logic        mem_RW;
    logic [7:0]  mem_addr;
    logic [31:0] mem_dataIN;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [2:0]  count;

    mem_req_queue #(.DEPTH(DEPTH), .ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_data(req_data),
        .mem_en(mem_en), .mem_RW(mem_RW), .mem_addr(mem_addr),
        .mem_dataIN(mem_dataIN), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference model: a plain queue of requests plus a response delay slot.
    typedef struct {
        logic        rw;
        logic [7:0]  addr;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    bit          m_pend;
    bit          m_rv;
    logic [31:0] m_rdata;

    task automatic tick();
        bit          do_push, do_pop, head_rw, r;
        ent_t        e;
        logic [31:0] rd;
        do_push = req_valid && (mq.size() < DEPTH);
        do_pop  = (mq.size() > 0) && mem_ready;
        head_rw = (mq.size() > 0) ? mq[0].rw : 1'b1;
        e.rw = req_rw; e.addr = req_addr; e.data = req_data;
        rd = mem_rdata;
        r  = rst;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_pend = 0; m_rv = 0; m_rdata = '0;
        end else begin
            m_rv = m_pend;
            if (m_pend) m_rdata = rd;
            m_pend = do_pop && !head_rw;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(e);
        end
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(mq.size()));
        chk({tag, ".req_ready"}, 32'(req_ready), 32'(mq.size() < DEPTH));
        chk({tag, ".mem_en"}, 32'(mem_en), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk({tag, ".mem_RW"}, 32'(mem_RW), 32'(mq[0].rw));
            chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(mq[0].addr));
            chk({tag, ".mem_dataIN"}, mem_dataIN, mq[0].data);
        end
        chk({tag, ".resp_valid"}, 32'(resp_valid), 32'(m_rv));
        if (m_rv) chk({tag, ".resp_data"}, resp_data, m_rdata);
    endtask

    task automatic drive(input bit r, input bit v, input bit rw, input logic [7:0] a,
                         input logic [31:0] d, input bit mr, input logic [31:0] rdat);
        rst = r; req_valid = v; req_rw = rw; req_addr = a; req_data = d;
        mem_ready = mr; mem_rdata = rdat;
    endtask

    typedef struct {
        bit          rst, v, rw;
        logic [7:0]  addr;
        logic [31:0] data;
        bit          mr;
        logic [31:0] rdat;
        logic [2:0]  e_cnt;
        bit          e_rdy, e_en, e_rw;
        logic [7:0]  e_addr;
        logic [31:0] e_data;
        bit          e_rv;
        logic [31:0] e_rdata;
        bit          chk_rd;
    } vec_t;

    function automatic vec_t mk(bit r, bit v, bit rw, logic [7:0] a, logic [31:0] d, bit mr,
                                logic [31:0] rdat, logic [2:0] ec, bit erdy, bit een, bit erw,
                                logic [7:0] ea, logic [31:0] ed, bit erv, logic [31:0] erd, bit crd);
        vec_t x;
        x.rst = r; x.v = v; x.rw = rw; x.addr = a; x.data = d; x.mr = mr; x.rdat = rdat;
        x.e_cnt = ec; x.e_rdy = erdy; x.e_en = een; x.e_rw = erw; x.e_addr = a;
        x.e_addr = ea; x.e_data = ed; x.e_rv = erv; x.e_rdata = erd; x.chk_rd = crd;
        return x;
    endfunction

    vec_t vecs[13];
    logic [31:0] seq[8];

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);
        m_pend = 0; m_rv = 0; m_rdata = '0;

        // Reset, idle, single write, then a read round trip.
        vecs[0]  = mk(1,0,0,8'h00,32'h0,0,32'h0,         0,1,0,0,8'h00,32'h0,0,32'h0,1);
        for (int i = 1; i <= 5; i++)
            vecs[i] = mk(0,0,0,8'h00,32'h0,0,32'h0,      0,1,0,0,8'h00,32'h0,0,32'h0,0);
        vecs[6]  = mk(0,1,1,8'h10,32'hDEADBEEF,1,32'h0,  1,1,1,1,8'h10,32'hDEADBEEF,0,32'h0,0);
        vecs[7]  = mk(0,0,0,8'h00,32'h0,1,32'h0,         0,1,0,0,8'h00,32'h0,0,32'h0,0);
        vecs[8]  = mk(0,0,0,8'h00,32'h0,0,32'h0,         0,1,0,0,8'h00,32'h0,0,32'h0,0);
        vecs[9]  = mk(0,1,0,8'h20,32'h0,0,32'h0,         1,1,1,0,8'h20,32'h0,0,32'h0,0);
        vecs[10] = mk(0,0,0,8'h00,32'h0,1,32'h0,         0,1,0,0,8'h00,32'h0,0,32'h0,0);
        vecs[11] = mk(0,0,0,8'h00,32'h0,1,32'hCAFE0001,  0,1,0,0,8'h00,32'h0,1,32'hCAFE0001,1);
        vecs[12] = mk(0,0,0,8'h00,32'h0,0,32'h0,         0,1,0,0,8'h00,32'h0,0,32'h0,0);

        foreach (vecs[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            drive(vecs[i].rst, vecs[i].v, vecs[i].rw, vecs[i].addr, vecs[i].data,
                  vecs[i].mr, vecs[i].rdat);
            tick();
            chk({t, ".count"}, 32'(count), 32'(vecs[i].e_cnt));
            chk({t, ".req_ready"}, 32'(req_ready), 32'(vecs[i].e_rdy));
            chk({t, ".mem_en"}, 32'(mem_en), 32'(vecs[i].e_en));
            if (vecs[i].e_en) begin
                chk({t, ".mem_RW"}, 32'(mem_RW), 32'(vecs[i].e_rw));
                chk({t, ".mem_addr"}, 32'(mem_addr), 32'(vecs[i].e_addr));
                chk({t, ".mem_dataIN"}, mem_dataIN, vecs[i].e_data);
            end
            chk({t, ".resp_valid"}, 32'(resp_valid), 32'(vecs[i].e_rv));
            if (vecs[i].chk_rd) chk({t, ".resp_data"}, resp_data, vecs[i].e_rdata);
        end

        // Fill to full with MAIN stalled, then drain in order.
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, 8'(8'h40 + i), 32'(i + 1), 0, 0);
            tick();
            chk("fill.count", 32'(count), 32'(i + 1));
        end
        chk("fill.req_ready", 32'(req_ready), 32'd0);
        drive(0, 1, 1, 8'h44, 32'd5, 0, 0);
        tick();
        chk("stall.count", 32'(count), 32'd4);
        chk("stall.req_ready", 32'(req_ready), 32'd0);
        drive(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            chk("drain.mem_en", 32'(mem_en), 32'd1);
            chk("drain.mem_dataIN", mem_dataIN, 32'(i + 1));
            tick();
        end
        chk("drain.empty_en", 32'(mem_en), 32'd0);
        chk("drain.count", 32'(count), 32'd0);

        // Steady push/pop at count=2 across pointer wrap.
        seq[0] = 32'hA0; seq[1] = 32'hA1;
        for (int i = 2; i < 8; i++) seq[i] = 32'hB0 + 32'(i - 2);
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 1, 8'h50, seq[i], 0, 0);
            tick();
        end
        for (int k = 0; k < 6; k++) begin
            chk("pp.count", 32'(count), 32'd2);
            chk("pp.mem_dataIN", mem_dataIN, seq[k]);
            drive(0, 1, 1, 8'h50, seq[k + 2], 1, 0);
            tick();
        end
        chk("pp.count_end", 32'(count), 32'd2);
        chk("pp.resp_valid", 32'(resp_valid), 32'd0);
        drive(0, 0, 0, 0, 0, 1, 0);
        tick(); tick();
        chk("pp.drained", 32'(count), 32'd0);

        // Reset with three entries queued and a read in flight.
        drive(0, 1, 0, 8'h30, 0, 0, 0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 8'(8'h31 + i), 32'(i), 0, 0); tick();
        end
        drive(0, 0, 0, 0, 0, 1, 0); tick();
        chk("rstmid.count_pre", 32'(count), 32'd3);
        drive(1, 0, 0, 0, 0, 0, 32'h12345678); tick();
        chk("rstmid.count", 32'(count), 32'd0);
        chk("rstmid.mem_en", 32'(mem_en), 32'd0);
        chk("rstmid.resp_valid", 32'(resp_valid), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 32'h12345678);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstmid.no_resp", 32'(resp_valid), 32'd0);
        end

        // Randomized traffic checked against the model every cycle.
        for (int c = 0; c < 500; c++) begin
            drive(($urandom % 64) == 0, $urandom % 2, $urandom % 2, 8'($urandom),
                  $urandom, ($urandom % 3) != 0, $urandom);
            tick();
            chk_model("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
